tx_sym_pack: RTL and testbench
==============================

TX_SYM_PACK -- requirements
Module: tx_sym_pack

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, symbol FIFO depth in symbols; power of two, >= 4.
REQ-002 Parameter START_CYC, default 4, clk_125 cycles of forced electrical idle after drate_enable rises.
REQ-003 clk_125  input  1  125 MHz clock; the only clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  TX path enable from the LTSSM.
REQ-006 ei_req  input  1  request to enter electrical idle.
REQ-007 sym_data  input  16  two symbols; [7:0] earlier in time, [15:8] later.
REQ-008 sym_k  input  2  K-flag per symbol; bit 0 pairs with [7:0].
REQ-009 sym_vld  input  2  per-symbol valid; legal values 00, 01, 11.
REQ-010 sym_ready  output  1  block can accept two symbols this cycle.
REQ-011 data_out  output  20  two 10-bit symbols {ei,k,data[7:0]}; [9:0] transmitted first; feeds the 20-bit TX gearbox.
REQ-012 drate_enable  output  1  enables the downstream 125->250 MHz gearbox.
REQ-013 underrun  output  1  one-cycle pulse when RUN/DRAIN idle-fills.

Function
REQ-014 An input symbol is accepted only in a cycle with sym_ready=1; sym_vld=10 is ignored (no push).
REQ-015 sym_ready = (state is START or RUN) and (FIFO_DEPTH - count) >= 2, evaluated combinationally from the registered count.
REQ-016 Push: vld=01 writes 1 symbol {k[0],data[7:0]}; vld=11 writes 2 in order [7:0] then [15:8]; write pointer wraps modulo FIFO_DEPTH.
REQ-017 Pop decisions use the count registered at cycle start; pushes in the same cycle do not affect the pop that cycle.
REQ-018 Count update per cycle = count + pushed - popped; simultaneous push and pop are both honored; count never exceeds FIFO_DEPTH or goes below 0.
REQ-019 States: OFF, START, RUN, DRAIN, EIDLE.
REQ-020 OFF: data_out = EI word 20'h80200 (both symbols 10'h200); drate_enable=0; FIFO flushed each cycle; next START when enable=1 and ei_req=0.
REQ-021 START: drate_enable=1; data_out = EI word; counter counts START_CYC cycles, then RUN.
REQ-022 RUN: count>=2: pop 2, data_out = {sym1,sym0} with ei=0; count=1: pop 1 into [9:0], [19:10] = logical idle 10'h000, underrun pulses; count=0: both halves 10'h000, underrun pulses.
REQ-023 RUN with ei_req=1: next DRAIN; the current cycle's pop proceeds normally.
REQ-024 DRAIN: sym_ready=0; pops as in RUN without underrun pulses; when count<=2 at cycle start, that cycle is the last data word and next state is EIDLE.
REQ-025 EIDLE: data_out = EI word; drate_enable stays 1; next RUN when ei_req=0.
REQ-026 enable=0 in any state: next state OFF; data_out = EI word and drate_enable=0 from the next cycle; FIFO content discarded.
REQ-027 data_out, drate_enable and underrun are registered; a symbol pushed in cycle n appears on data_out no earlier than cycle n+2.
REQ-028 Symbol order is preserved end to end; no symbol is duplicated or dropped except on enable=0 or rst.

Reset
REQ-029 While rst=1 at a clk_125 edge: state OFF, count 0, pointers 0, START counter 0, data_out = 20'h80200, drate_enable=0, underrun=0; sym_ready=0 follows from OFF.
REQ-030 rst mid-operation discards all FIFO content; output returns to the EI word on the next edge.

Verification
REQ-031 Reset, then enable=1, ei_req=0 -> drate_enable=1 one cycle after OFF exit; EI word for 4 cycles; then RUN with data_out = 20'h00000 and underrun=1 each cycle.
REQ-032 In RUN, push vld=11 data=16'hBC1C k=2'b01 -> two cycles later data_out = {10'h0BC,10'h11C}.
REQ-033 Hold vld=11 continuously with a 1-cycle push stall -> FIFO never overflows; sym_ready drops when free<2; output order matches input order.
REQ-034 In RUN with 3 symbols queued, raise ei_req -> one full word, then one word with the last symbol in [9:0] and 10'h000 in [19:10], then the EI word; underrun stays 0.
REQ-035 enable=0 while in RUN with data queued -> next cycle data_out = 20'h80200, drate_enable=0; re-enable yields no stale symbols.
REQ-036 Alternate vld=01 each cycle in RUN -> the count=1 path fills with 10'h000 and pulses underrun; symbol order is preserved.

Source files
------------

// File: rtl/tx_sym_pack.sv
// tx_sym_pack: packs 8b symbols with K flags into 20-bit double-symbol words
// for the TX gearbox, with electrical-idle sequencing and idle fill on underrun.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// OFF    | TX disabled; EI word out, gearbox off, FIFO held empty
// START  | gearbox enabled, EI word out for START_CYC cycles, FIFO may fill
// RUN    | pop up to two symbols per cycle; idle-fill and flag underrun
// DRAIN  | EI requested; empty the FIFO without accepting new symbols
// EIDLE  | EI word out with gearbox running; resume RUN when EI released
module tx_sym_pack #(
    parameter int FIFO_DEPTH = 8,
    parameter int START_CYC  = 4
) (
    input  logic        clk_125,
    input  logic        rst,
    input  logic        enable,
    input  logic        ei_req,
    input  logic [15:0] sym_data,
    input  logic [1:0]  sym_k,
    input  logic [1:0]  sym_vld,
    output logic        sym_ready,
    output logic [19:0] data_out,
    output logic        drate_enable,
    output logic        underrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMR_LOAD = TW'(START_CYC - 1);
    localparam logic [9:0]    SYM_IDLE = 10'h000;
    localparam logic [19:0]   EI_WORD  = 20'h80200;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_START,
        ST_RUN,
        ST_DRAIN,
        ST_EIDLE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   start_tmr;
    logic [8:0]      fifo_mem [FIFO_DEPTH];

    logic [CW-1:0]   free_cnt;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    logic [PW-1:0]   wr_ptr1;
    logic [PW-1:0]   rd_ptr1;
    logic [CW-1:0]   count_nxt;
    logic [19:0]     pop_word;

    // Handshake, push/pop sizing and the outgoing word, all from registered count.
    always_comb begin
        free_cnt  = DEPTH_C - count;
        sym_ready = ((state == ST_START) || (state == ST_RUN)) && (free_cnt >= CW'(2));

        push_n = 2'd0;
        if (sym_ready) begin
            if (sym_vld == 2'b01) begin
                push_n = 2'd1;
            end else if (sym_vld == 2'b11) begin
                push_n = 2'd2;
            end
        end

        pop_n = 2'd0;
        if ((state == ST_RUN) || (state == ST_DRAIN)) begin
            if (count >= CW'(2)) begin
                pop_n = 2'd2;
            end else if (count == CW'(1)) begin
                pop_n = 2'd1;
            end
        end

        wr_ptr1   = wr_ptr + PW'(1);
        rd_ptr1   = rd_ptr + PW'(1);
        count_nxt = count + CW'(push_n) - CW'(pop_n);

        pop_word = {SYM_IDLE, SYM_IDLE};
        if (pop_n == 2'd2) begin
            pop_word = {1'b0, fifo_mem[rd_ptr1], 1'b0, fifo_mem[rd_ptr]};
        end else if (pop_n == 2'd1) begin
            pop_word = {SYM_IDLE, 1'b0, fifo_mem[rd_ptr]};
        end
    end

    // Symbol storage; slots are only written when at least two are free.
    always_ff @(posedge clk_125) begin
        if (push_n != 2'd0) begin
            fifo_mem[wr_ptr] <= {sym_k[0], sym_data[7:0]};
        end
        if (push_n == 2'd2) begin
            fifo_mem[wr_ptr1] <= {sym_k[1], sym_data[15:8]};
        end
    end

    // Sequencing FSM with FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk_125) begin
        if (rst || !enable) begin
            state        <= ST_OFF;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            start_tmr    <= '0;
            data_out     <= EI_WORD;
            drate_enable <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            count  <= count_nxt;
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            case (state)
                ST_OFF: begin
                    count        <= '0;
                    wr_ptr       <= '0;
                    rd_ptr       <= '0;
                    data_out     <= EI_WORD;
                    drate_enable <= 1'b0;
                    underrun     <= 1'b0;
                    if (!ei_req) begin
                        state     <= ST_START;
                        start_tmr <= TMR_LOAD;
                    end
                end
                ST_START: begin
                    data_out     <= EI_WORD;
                    drate_enable <= 1'b1;
                    underrun     <= 1'b0;
                    if (start_tmr == '0) begin
                        state <= ST_RUN;
                    end else begin
                        start_tmr <= start_tmr - TW'(1);
                    end
                end
                ST_RUN: begin
                    data_out     <= pop_word;
                    drate_enable <= 1'b1;
                    underrun     <= (count < CW'(2));
                    if (ei_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    data_out     <= pop_word;
                    drate_enable <= 1'b1;
                    underrun     <= 1'b0;
                    if (count <= CW'(2)) begin
                        state <= ST_EIDLE;
                    end
                end
                ST_EIDLE: begin
                    data_out     <= EI_WORD;
                    drate_enable <= 1'b1;
                    underrun     <= 1'b0;
                    if (!ei_req) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state        <= ST_OFF;
                    data_out     <= EI_WORD;
                    drate_enable <= 1'b0;
                    underrun     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sym_pack.sv
// Bench for tx_sym_pack: directed sequences plus random traffic, checked every
// cycle against a queue-based model of the symbol stream and mode sequencing.
module tb_tx_sym_pack;

    localparam int          DEPTH   = 8;
    localparam int          SCYC    = 4;
    localparam logic [19:0] EI_WORD = 20'h80200;

    logic        clk_125 = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b0;
    logic        ei_req  = 1'b0;
    logic [15:0] sym_data = '0;
    logic [1:0]  sym_k    = '0;
    logic [1:0]  sym_vld  = '0;
    logic        sym_ready;
    logic [19:0] data_out;
    logic        drate_enable;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    tx_sym_pack #(.FIFO_DEPTH(DEPTH), .START_CYC(SCYC)) dut (
        .clk_125      (clk_125),
        .rst          (rst),
        .enable       (enable),
        .ei_req       (ei_req),
        .sym_data     (sym_data),
        .sym_k        (sym_k),
        .sym_vld      (sym_vld),
        .sym_ready    (sym_ready),
        .data_out     (data_out),
        .drate_enable (drate_enable),
        .underrun     (underrun)
    );

    always #4 clk_125 = ~clk_125;

    typedef enum {M_OFF, M_START, M_RUN, M_DRAIN, M_EIDLE} mmode_t;

    mmode_t      m_mode = M_OFF;
    logic [8:0]  m_q[$];
    int          m_start_left = 0;
    logic [19:0] e_data  = EI_WORD;
    logic        e_drate = 1'b0;
    logic        e_und   = 1'b0;

    function automatic logic m_ready();
        return ((m_mode == M_START) || (m_mode == M_RUN)) && ((DEPTH - m_q.size()) >= 2);
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_step();
        int         c;
        logic [9:0] lo;
        logic [9:0] hi;
        logic       rdy;
        rdy = m_ready();
        if (rst || !enable) begin
            m_mode = M_OFF;
            m_q.delete();
            e_data = EI_WORD;
            e_drate = 1'b0;
            e_und = 1'b0;
            return;
        end
        c  = m_q.size();
        lo = 10'h000;
        hi = 10'h000;
        if ((m_mode == M_RUN) || (m_mode == M_DRAIN)) begin
            if (c >= 1) lo = {1'b0, m_q.pop_front()};
            if (c >= 2) hi = {1'b0, m_q.pop_front()};
        end
        if (rdy && (sym_vld == 2'b01)) begin
            m_q.push_back({sym_k[0], sym_data[7:0]});
        end else if (rdy && (sym_vld == 2'b11)) begin
            m_q.push_back({sym_k[0], sym_data[7:0]});
            m_q.push_back({sym_k[1], sym_data[15:8]});
        end
        case (m_mode)
            M_OFF: begin
                m_q.delete();
                e_data = EI_WORD; e_drate = 1'b0; e_und = 1'b0;
                if (!ei_req) begin
                    m_mode = M_START;
                    m_start_left = SCYC;
                end
            end
            M_START: begin
                e_data = EI_WORD; e_drate = 1'b1; e_und = 1'b0;
                m_start_left--;
                if (m_start_left == 0) m_mode = M_RUN;
            end
            M_RUN: begin
                e_data = {hi, lo}; e_drate = 1'b1; e_und = (c < 2);
                if (ei_req) m_mode = M_DRAIN;
            end
            M_DRAIN: begin
                e_data = {hi, lo}; e_drate = 1'b1; e_und = 1'b0;
                if (c <= 2) m_mode = M_EIDLE;
            end
            default: begin
                e_data = EI_WORD; e_drate = 1'b1; e_und = 1'b0;
                if (!ei_req) m_mode = M_RUN;
            end
        endcase
    endtask

    // One clock: check outputs mid-cycle, step the model, land just after the edge.
    task automatic cycle();
        @(negedge clk_125);
        chk("sym_ready", 20'(sym_ready), 20'(m_ready()));
        chk("data_out", data_out, e_data);
        chk("drate_enable", 20'(drate_enable), 20'(e_drate));
        chk("underrun", 20'(underrun), 20'(e_und));
        model_step();
        @(posedge clk_125);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drive(input logic [1:0] vld, input logic [15:0] d, input logic [1:0] k);
        sym_vld = vld;
        sym_data = d;
        sym_k = k;
    endtask

    task automatic rand_sym(input logic [1:0] vld);
        drive(vld, 16'($urandom), 2'($urandom));
    endtask

    task automatic wait_run();
        for (int i = 0; i < 12 && m_mode != M_RUN; i++) cycle();
        chk("reach_run", 20'(m_mode == M_RUN), 20'(1));
    endtask

    initial begin
        repeat (2) @(posedge clk_125);
        #1;
        // reset state
        run(3);
        chk("reset_data", data_out, EI_WORD);
        chk("reset_ready", 20'(sym_ready), 20'(0));

        // bring-up: EI for START_CYC cycles then idle fill with underrun
        rst = 1'b0;
        enable = 1'b1;
        run(10);
        chk("run_idle_word", data_out, 20'h00000);
        chk("run_idle_underrun", 20'(underrun), 20'(1));

        // single push of two symbols, visible two cycles later
        drive(2'b11, 16'hBC1C, 2'b01);
        cycle();
        drive(2'b00, 16'h0000, 2'b00);
        cycle();
        chk("bc1c_word", data_out, 20'h2F11C);
        chk("bc1c_underrun", 20'(underrun), 20'(0));
        run(2);

        // vld=10 never pushes
        drive(2'b10, 16'hFFFF, 2'b11);
        run(3);
        drive(2'b00, 16'h0000, 2'b00);

        // continuous vld=11 from restart with periodic stalls; FIFO fills in START
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_sym((i % 5 == 4) ? 2'b00 : 2'b11);
            cycle();
        end
        drive(2'b00, 16'h0000, 2'b00);
        run(6);

        // three symbols queued at RUN entry, then EI request
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        cycle();
        drive(2'b11, 16'h2211, 2'b00);
        cycle();
        drive(2'b01, 16'h0033, 2'b00);
        cycle();
        drive(2'b00, 16'h0000, 2'b00);
        wait_run();
        ei_req = 1'b1;
        cycle();
        chk("drain_full_word", data_out, 20'h08811);
        cycle();
        chk("drain_last_word", data_out, 20'h00033);
        chk("drain_no_underrun", 20'(underrun), 20'(0));
        cycle();
        chk("eidle_word", data_out, EI_WORD);
        chk("eidle_drate", 20'(drate_enable), 20'(1));
        run(3);
        ei_req = 1'b0;
        run(4);

        // disable with data queued; no stale symbols after re-enable
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        cycle();
        drive(2'b11, 16'h5A4B, 2'b10);
        cycle();
        cycle();
        drive(2'b00, 16'h0000, 2'b00);
        wait_run();
        enable = 1'b0;
        cycle();
        chk("disable_word", data_out, EI_WORD);
        chk("disable_drate", 20'(drate_enable), 20'(0));
        enable = 1'b1;
        run(10);
        chk("reenable_idle", data_out, 20'h00000);

        // alternating single-symbol pushes exercise the count=1 path
        for (int i = 0; i < 20; i++) begin
            rand_sym((i % 2 == 0) ? 2'b01 : 2'b00);
            cycle();
        end
        drive(2'b00, 16'h0000, 2'b00);
        run(3);

        // reset mid-operation with data queued
        for (int i = 0; i < 3; i++) begin
            rand_sym(2'b11);
            cycle();
        end
        rst = 1'b1;
        cycle();
        chk("midrst_word", data_out, EI_WORD);
        rst = 1'b0;
        drive(2'b00, 16'h0000, 2'b00);
        run(8);

        // random traffic with occasional EI requests and disables
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: rand_sym(2'b00);
                1: rand_sym(2'b01);
                2: rand_sym(2'b11);
                default: rand_sym(2'b10);
            endcase
            if ($urandom_range(0, 15) == 0) ei_req = ~ei_req;
            enable = ($urandom_range(0, 49) != 0);
            cycle();
        end
        drive(2'b00, 16'h0000, 2'b00);
        enable = 1'b1;
        ei_req = 1'b0;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
